mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port word memory (sync write, 1-cycle registered read) between
//  the instruction-fetch port (I) and the load/store data port (D).
//  Per cycle: grants at most one valid/ready request, converts the byte address to a
//  word index, range- and alignment-checks it, and drives the memory.
//  Returns exactly one response per accepted request, on the port that issued it.
//  Supports a D-side lock, so a read-modify-write sequence is never interleaved with fetch.
// PARAMETERS
//  SIZE    1024  memory depth in 32-bit words; word index must be < SIZE
//  ADDR_W  32    request byte-address width
// PORTS
//  clk              in   1       clock, all state on posedge
//  reset            in   1       asynchronous, active-low reset
//  i_req_valid      in   1       fetch request present
//  i_req_ready      out  1       fetch request accepted this cycle (valid&&ready)
//  i_req_addr       in   ADDR_W  fetch byte address
//  i_rsp_valid      out  1       fetch response, one-cycle pulse
//  i_rsp_data       out  32      fetch read data
//  i_rsp_err        out  1       fetch address misaligned or out of range
//  d_req_valid      in   1       data request present
//  d_req_ready      out  1       data request accepted this cycle
//  d_req_we         in   1       1=write, 0=read
//  d_req_addr       in   ADDR_W  data byte address
//  d_req_wdata      in   32      write data
//  d_req_lock       in   1       hold D ownership after this request
//  d_rsp_valid      out  1       data response, one-cycle pulse
//  d_rsp_data       out  32      read data (0 for writes and errors)
//  d_rsp_err        out  1       data address misaligned or out of range
//  mem_writeaddr    out  32      memory write word index
//  mem_writedata    out  32      memory write data
//  mem_writeenable  out  1       memory write strobe
//  mem_readaddr     out  32      memory read word index
//  mem_readdata     in   32      memory read data, valid 1 cycle after mem_readaddr
// BEHAVIOUR
//  - Reset (async, while low): state=ARB, last_q=D, both rsp_valid=0, both req_ready=0,
//    mem_writeenable=0. Pending responses are dropped, no later pulse.
//  - Ready is combinational from valid and state. At most one of i_req_ready or
//    d_req_ready is 1 per cycle. Ready is never 1 while that port's valid is 0.
//  - ARB state:
//      only one port valid -> grant it;
//      both valid -> grant the port not in last_q (round-robin).
//    last_q updates on every accept.
//  - LOCKED state: i_req_ready=0; D is granted whenever d_req_valid=1.
//  - State transitions:
//      ARB -> LOCKED on D accept with d_req_lock=1;
//      LOCKED -> ARB on D accept with d_req_lock=0;
//      LOCKED is held indefinitely while D is idle.
//  - Address check: idx = addr>>2.
//      err = (addr[1:0]!=0) || (idx >= SIZE).
//    err requests never touch memory.
//  - Memory drive in the accept cycle:
//      mem_readaddr = mem_writeaddr = idx;
//      mem_writedata = d_req_wdata;
//      mem_writeenable = D accept && d_req_we && !err.
//    With no accept: mem_writeenable=0, addresses 0.
//  - Response: request accepted in cycle N gives rsp_valid=1 in cycle N+1 only, on the
//    requesting port. Registered state: rsp_port_q, rsp_rd_q, rsp_err_q.
//  - rsp_data = mem_readdata for a non-err read, else 0. rsp_err = rsp_err_q.
//    Responses are always accepted; there is no response backpressure.
//  - Throughput is one access per cycle. Back-to-back accepts give back-to-back responses.
//  - A write at N followed by a read of the same idx at N+1 returns the new data.
//  - rsp_valid on a port while that port is being granted again is legal (pipelined).
// TESTING
//  1. D write 0x10 <- 0xDEADBEEF, then I read 0x10 -> d_rsp_valid next cycle (data 0,
//     err 0); i_rsp_data=0xDEADBEEF one cycle after the I accept.
//  2. i_req_valid and d_req_valid both held high 4 cycles after reset -> accepts I,D,I,D;
//     responses alternate i/d each cycle.
//  3. D read 0x20 with lock=1, I valid throughout, D write 0x20 with lock=0 two cycles
//     later -> i_req_ready=0 until the D unlocking write is accepted; I granted the
//     following cycle.
//  4. D write to 0x22 (misaligned) -> mem_writeenable stays 0, d_rsp_err=1, data 0;
//     a later read of 0x20 is unchanged.
//  5. I read 0x1000 with SIZE=1024 -> i_rsp_err=1, i_rsp_data=0.
//  6. Assert reset in LOCKED with a response pending -> rsp_valid=0 on both ports;
//     after release, I is granted on the first contention (ARB, last_q=D).

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// I/D request-response channels plus the word-memory drive, shared by arbiter and environment.
// slave = arbiter view, master = requesters/memory view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              i_req_valid;
    logic              i_req_ready;
    logic [ADDR_W-1:0] i_req_addr;
    logic              i_rsp_valid;
    logic [31:0]       i_rsp_data;
    logic              i_rsp_err;

    logic              d_req_valid;
    logic              d_req_ready;
    logic              d_req_we;
    logic [ADDR_W-1:0] d_req_addr;
    logic [31:0]       d_req_wdata;
    logic              d_req_lock;
    logic              d_rsp_valid;
    logic [31:0]       d_rsp_data;
    logic              d_rsp_err;

    logic [31:0]       mem_writeaddr;
    logic [31:0]       mem_writedata;
    logic              mem_writeenable;
    logic [31:0]       mem_readaddr;
    logic [31:0]       mem_readdata;

    modport slave (
        input  i_req_valid, i_req_addr,
        input  d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_lock,
        input  mem_readdata,
        output i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_err,
        output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
        output mem_writeaddr, mem_writedata, mem_writeenable, mem_readaddr
    );

    modport master (
        output i_req_valid, i_req_addr,
        output d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_lock,
        output mem_readdata,
        input  i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_err,
        input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
        input  mem_writeaddr, mem_writedata, mem_writeenable, mem_readaddr
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin I/D sharing of one sync word memory, with a D lock for read-modify-write.
// Latency: response exactly 1 cycle after accept; backpressure only via req_ready, none on responses.
module mem_port_arbiter #(
    parameter int SIZE   = 1024,
    parameter int ADDR_W = 32
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef struct packed {
        logic vld;
        logic port;
        logic rd;
        logic err;
    } rsp_t;

    state_t            state_q;
    state_t            state_d;
    logic              last_q;
    rsp_t              rsp_q;
    logic              i_acc;
    logic              d_acc;
    logic              acc;
    logic [ADDR_W-1:0] sel_addr;
    logic [ADDR_W-1:0] idx;
    logic              addr_err;
    logic [31:0]       rsp_data;
    logic              i_rsp_vld;
    logic              d_rsp_vld;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // Every D accept re-decides ownership from its own lock bit.
    always_comb begin
        state_d = state_q;
        if (d_acc) begin
            state_d = bus.d_req_lock ? LOCKED : ARB;
        end
    end

    always_comb begin
        i_acc = 1'b0;
        d_acc = 1'b0;
        if (reset) begin
            case (state_q)
                ARB: begin
                    if (bus.i_req_valid && bus.d_req_valid) begin
                        i_acc = (last_q == PORT_D);
                        d_acc = (last_q == PORT_I);
                    end else begin
                        i_acc = bus.i_req_valid;
                        d_acc = bus.d_req_valid;
                    end
                end
                LOCKED: d_acc = bus.d_req_valid;
            endcase
        end
    end

    assign acc      = i_acc || d_acc;
    assign sel_addr = d_acc ? bus.d_req_addr : bus.i_req_addr;
    assign idx      = sel_addr >> 2;
    assign addr_err = (sel_addr[1:0] != 2'b00) || (idx >= ADDR_W'(SIZE));

    assign bus.i_req_ready     = i_acc;
    assign bus.d_req_ready     = d_acc;
    assign bus.mem_writeenable = d_acc && bus.d_req_we && !addr_err;
    assign bus.mem_writeaddr   = acc ? 32'(idx) : 32'd0;
    assign bus.mem_readaddr    = acc ? 32'(idx) : 32'd0;
    assign bus.mem_writedata   = acc ? bus.d_req_wdata : 32'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_q  <= '0;
            last_q <= PORT_D;
        end else begin
            rsp_q.vld <= acc;
            if (acc) begin
                rsp_q.port <= d_acc ? PORT_D : PORT_I;
                rsp_q.rd   <= i_acc || !bus.d_req_we;
                rsp_q.err  <= addr_err;
                last_q     <= d_acc ? PORT_D : PORT_I;
            end
        end
    end

    // Memory read data lands in the cycle after the accept, aligned with rsp_q.
    assign rsp_data  = (rsp_q.rd && !rsp_q.err) ? bus.mem_readdata : 32'd0;
    assign i_rsp_vld = rsp_q.vld && (rsp_q.port == PORT_I);
    assign d_rsp_vld = rsp_q.vld && (rsp_q.port == PORT_D);

    assign bus.i_rsp_valid = i_rsp_vld;
    assign bus.i_rsp_data  = i_rsp_vld ? rsp_data : 32'd0;
    assign bus.i_rsp_err   = i_rsp_vld && rsp_q.err;
    assign bus.d_rsp_valid = d_rsp_vld;
    assign bus.d_rsp_data  = d_rsp_vld ? rsp_data : 32'd0;
    assign bus.d_rsp_err   = d_rsp_vld && rsp_q.err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_mem_port_arbiter;
    localparam int SIZE   = 1024;
    localparam int ADDR_W = 32;
    localparam int AW     = $clog2(SIZE);

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] mem     [SIZE];
    logic [31:0] exp_mem [SIZE];
    bit          mem_init_done = 1'b0;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
    mem_port_arbiter #(.SIZE(SIZE), .ADDR_W(ADDR_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Word memory: sync write, registered read; out-of-range reads return junk.
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < SIZE; i++) mem[i] <= 32'(i) * 32'h9E37_79B9;
            mem_init_done <= 1'b1;
        end else if (bus.mem_writeenable && bus.mem_writeaddr < SIZE) begin
            mem[bus.mem_writeaddr[AW-1:0]] <= bus.mem_writedata;
        end
        bus.mem_readdata <= (bus.mem_readaddr < SIZE) ? mem[bus.mem_readaddr[AW-1:0]] : 32'hBAD0_BAD0;
    end

    task automatic drive(input logic iv, input logic [31:0] ia, input logic dv, input logic dwe,
                         input logic [31:0] da, input logic [31:0] dwd, input logic dl);
        bus.i_req_valid = iv;
        bus.i_req_addr  = ia;
        bus.d_req_valid = dv;
        bus.d_req_we    = dwe;
        bus.d_req_addr  = da;
        bus.d_req_wdata = dwd;
        bus.d_req_lock  = dl;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle();
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a / 4 >= SIZE);
    endfunction

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return ($urandom_range(0, 15) << 2) | $urandom_range(1, 3);
        if (r == 1) return 32'(SIZE * 4) + ($urandom_range(0, 3) << 2);
        if (r == 2) return 32'h8000_0000 | ($urandom_range(0, 255) << 2);
        if (r == 3) return 32'((SIZE - 1) * 4);
        return $urandom_range(0, 15) << 2;
    endfunction

    task automatic test_reset();
        drive(1'b1, 32'h0, 1'b1, 1'b1, 32'h4, 32'h1, 1'b1);
        cyc();
        @(negedge clk);
        checks++; if (bus.i_req_ready !== 1'b0) begin errors++; $display("FAIL rst_i_ready: got %b want 0", bus.i_req_ready); end
        checks++; if (bus.d_req_ready !== 1'b0) begin errors++; $display("FAIL rst_d_ready: got %b want 0", bus.d_req_ready); end
        checks++; if (bus.mem_writeenable !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", bus.mem_writeenable); end
        checks++; if (bus.i_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_i_rsp: got %b want 0", bus.i_rsp_valid); end
        checks++; if (bus.d_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_d_rsp: got %b want 0", bus.d_rsp_valid); end
        cyc();
        reset = 1'b1;
        idle();
    endtask

    task automatic test_contention();
        drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (bus.i_req_ready !== (k % 2 == 0)) begin errors++; $display("FAIL rr_i_ready k=%0d: got %b", k, bus.i_req_ready); end
            checks++; if (bus.d_req_ready !== (k % 2 == 1)) begin errors++; $display("FAIL rr_d_ready k=%0d: got %b", k, bus.d_req_ready); end
            if (k > 0) begin
                checks++; if (bus.i_rsp_valid !== ((k - 1) % 2 == 0)) begin errors++; $display("FAIL rr_i_rsp k=%0d: got %b", k, bus.i_rsp_valid); end
                checks++; if (bus.d_rsp_valid !== ((k - 1) % 2 == 1)) begin errors++; $display("FAIL rr_d_rsp k=%0d: got %b", k, bus.d_rsp_valid); end
            end
            cyc();
        end
        idle();
        @(negedge clk);
        checks++; if (bus.d_rsp_valid !== 1'b1 || bus.i_rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_last_rsp: got i=%b d=%b want i=0 d=1", bus.i_rsp_valid, bus.d_rsp_valid); end
        cyc();
    endtask

    task automatic test_write_then_read();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        checks++; if (bus.d_req_ready !== 1'b1) begin errors++; $display("FAIL wr_d_ready: got %b want 1", bus.d_req_ready); end
        checks++; if (bus.mem_writeenable !== 1'b1) begin errors++; $display("FAIL wr_we: got %b want 1", bus.mem_writeenable); end
        checks++; if (bus.mem_writeaddr !== 32'h4) begin errors++; $display("FAIL wr_waddr: got %h want 4", bus.mem_writeaddr); end
        checks++; if (bus.mem_writedata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_wdata: got %h want deadbeef", bus.mem_writedata); end
        cyc();
        drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        checks++; if (bus.i_req_ready !== 1'b1) begin errors++; $display("FAIL rd_i_ready: got %b want 1", bus.i_req_ready); end
        checks++; if (bus.mem_readaddr !== 32'h4) begin errors++; $display("FAIL rd_raddr: got %h want 4", bus.mem_readaddr); end
        checks++; if (bus.d_rsp_valid !== 1'b1) begin errors++; $display("FAIL wr_rsp_valid: got %b want 1", bus.d_rsp_valid); end
        checks++; if (bus.d_rsp_data !== 32'h0 || bus.d_rsp_err !== 1'b0) begin errors++; $display("FAIL wr_rsp: got data=%h err=%b want 0/0", bus.d_rsp_data, bus.d_rsp_err); end
        cyc();
        idle();
        @(negedge clk);
        checks++; if (bus.i_rsp_valid !== 1'b1) begin errors++; $display("FAIL rd_rsp_valid: got %b want 1", bus.i_rsp_valid); end
        checks++; if (bus.i_rsp_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rsp_data: got %h want deadbeef", bus.i_rsp_data); end
        checks++; if (bus.d_rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_no_d_rsp: got %b want 0", bus.d_rsp_valid); end
        cyc();
    endtask

    task automatic test_lock();
        drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        cyc();
        drive(1'b1, 32'h8, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
        @(negedge clk);
        checks++; if (bus.d_req_ready !== 1'b1 || bus.i_req_ready !== 1'b0) begin errors++; $display("FAIL lk_grant0: got i=%b d=%b want i=0 d=1", bus.i_req_ready, bus.d_req_ready); end
        cyc();
        drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        checks++; if (bus.i_req_ready !== 1'b0) begin errors++; $display("FAIL lk_hold_i: got %b want 0", bus.i_req_ready); end
        checks++; if (bus.d_rsp_valid !== 1'b1) begin errors++; $display("FAIL lk_rsp: got %b want 1", bus.d_rsp_valid); end
        cyc();
        drive(1'b1, 32'h20, 1'b1, 1'b1, 32'h20, 32'hCAFE_F00D, 1'b0);
        @(negedge clk);
        checks++; if (bus.d_req_ready !== 1'b1 || bus.i_req_ready !== 1'b0) begin errors++; $display("FAIL lk_unlock: got i=%b d=%b want i=0 d=1", bus.i_req_ready, bus.d_req_ready); end
        cyc();
        drive(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        checks++; if (bus.i_req_ready !== 1'b1) begin errors++; $display("FAIL lk_i_after: got %b want 1", bus.i_req_ready); end
        cyc();
        idle();
        @(negedge clk);
        checks++; if (bus.i_rsp_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL lk_rmw_data: got %h want cafef00d", bus.i_rsp_data); end
        cyc();
    endtask

    task automatic test_misaligned();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h1357_9BDF, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h22, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk);
        checks++; if (bus.d_req_ready !== 1'b1) begin errors++; $display("FAIL mis_ready: got %b want 1", bus.d_req_ready); end
        checks++; if (bus.mem_writeenable !== 1'b0) begin errors++; $display("FAIL mis_we: got %b want 0", bus.mem_writeenable); end
        cyc();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
        @(negedge clk);
        checks++; if (bus.d_rsp_err !== 1'b1) begin errors++; $display("FAIL mis_err: got %b want 1", bus.d_rsp_err); end
        checks++; if (bus.d_rsp_data !== 32'h0) begin errors++; $display("FAIL mis_data: got %h want 0", bus.d_rsp_data); end
        cyc();
        idle();
        @(negedge clk);
        checks++; if (bus.d_rsp_data !== 32'h1357_9BDF || bus.d_rsp_err !== 1'b0) begin errors++; $display("FAIL mis_keep: got %h err=%b want 13579bdf/0", bus.d_rsp_data, bus.d_rsp_err); end
        cyc();
    endtask

    task automatic test_out_of_range();
        drive(1'b1, 32'(SIZE * 4 - 4), 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        cyc();
        drive(1'b1, 32'(SIZE * 4), 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        checks++; if (bus.i_rsp_err !== 1'b0) begin errors++; $display("FAIL oor_last_word_err: got %b want 0", bus.i_rsp_err); end
        checks++; if (bus.i_req_ready !== 1'b1) begin errors++; $display("FAIL oor_ready: got %b want 1", bus.i_req_ready); end
        cyc();
        idle();
        @(negedge clk);
        checks++; if (bus.i_rsp_valid !== 1'b1 || bus.i_rsp_err !== 1'b1) begin errors++; $display("FAIL oor_err: got v=%b err=%b want 1/1", bus.i_rsp_valid, bus.i_rsp_err); end
        checks++; if (bus.i_rsp_data !== 32'h0) begin errors++; $display("FAIL oor_data: got %h want 0", bus.i_rsp_data); end
        cyc();
    endtask

    task automatic test_reset_in_lock();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        checks++; if (bus.d_req_ready !== 1'b1) begin errors++; $display("FAIL rl_lock_acc: got %b want 1", bus.d_req_ready); end
        cyc();
        reset = 1'b0;
        drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        checks++; if (bus.d_rsp_valid !== 1'b0 || bus.i_rsp_valid !== 1'b0) begin errors++; $display("FAIL rl_drop: got i=%b d=%b want 0/0", bus.i_rsp_valid, bus.d_rsp_valid); end
        cyc();
        reset = 1'b1;
        drive(1'b1, 32'h4, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
        @(negedge clk);
        checks++; if (bus.i_req_ready !== 1'b1 || bus.d_req_ready !== 1'b0) begin errors++; $display("FAIL rl_first_grant: got i=%b d=%b want 1/0", bus.i_req_ready, bus.d_req_ready); end
        checks++; if (bus.d_rsp_valid !== 1'b0 || bus.i_rsp_valid !== 1'b0) begin errors++; $display("FAIL rl_no_stale: got i=%b d=%b want 0/0", bus.i_rsp_valid, bus.d_rsp_valid); end
        cyc();
        idle();
        @(negedge clk);
        checks++; if (bus.i_rsp_valid !== 1'b1) begin errors++; $display("FAIL rl_rsp: got %b want 1", bus.i_rsp_valid); end
        cyc();
    endtask

    task automatic test_random(input int n);
        bit          locked_m = 1'b0;
        bit          last_d_m = 1'b1;
        bit          pv_i = 1'b0;
        bit          pv_d = 1'b0;
        bit          perr = 1'b0;
        logic [31:0] pdata = 32'h0;
        logic        iv, dv, dwe, dl;
        logic [31:0] ia, da, dwd, a, ix;
        bit          gi, gd, we_exp;
        do_reset();
        for (int k = 0; k < SIZE; k++) exp_mem[k] = mem[k];
        for (int c = 0; c <= n; c++) begin
            if (c < n) begin
                iv  = ($urandom_range(0, 3) != 0);
                dv  = ($urandom_range(0, 3) != 0);
                dwe = $urandom_range(0, 1) == 1;
                dl  = ($urandom_range(0, 3) == 0);
                ia  = rand_addr();
                da  = rand_addr();
                dwd = $urandom;
            end else begin
                iv = 1'b0; dv = 1'b0; dwe = 1'b0; dl = 1'b0; ia = 32'h0; da = 32'h0; dwd = 32'h0;
            end
            drive(iv, ia, dv, dwe, da, dwd, dl);
            gi = 1'b0;
            gd = 1'b0;
            if (locked_m) gd = dv;
            else if (iv && dv) begin gi = last_d_m; gd = !last_d_m; end
            else begin gi = iv; gd = dv; end
            we_exp = gd && dwe && !addr_bad(da);
            @(negedge clk);
            checks++; if (bus.i_req_ready !== gi) begin errors++; $display("FAIL rnd_i_ready c=%0d: got %b want %b", c, bus.i_req_ready, gi); end
            checks++; if (bus.d_req_ready !== gd) begin errors++; $display("FAIL rnd_d_ready c=%0d: got %b want %b", c, bus.d_req_ready, gd); end
            checks++; if (bus.mem_writeenable !== we_exp) begin errors++; $display("FAIL rnd_we c=%0d: got %b want %b", c, bus.mem_writeenable, we_exp); end
            checks++; if (bus.i_rsp_valid !== pv_i) begin errors++; $display("FAIL rnd_i_rsp c=%0d: got %b want %b", c, bus.i_rsp_valid, pv_i); end
            checks++; if (bus.d_rsp_valid !== pv_d) begin errors++; $display("FAIL rnd_d_rsp c=%0d: got %b want %b", c, bus.d_rsp_valid, pv_d); end
            if (pv_i) begin
                checks++; if (bus.i_rsp_data !== pdata || bus.i_rsp_err !== perr) begin errors++; $display("FAIL rnd_i_data c=%0d: got %h/%b want %h/%b", c, bus.i_rsp_data, bus.i_rsp_err, pdata, perr); end
            end
            if (pv_d) begin
                checks++; if (bus.d_rsp_data !== pdata || bus.d_rsp_err !== perr) begin errors++; $display("FAIL rnd_d_data c=%0d: got %h/%b want %h/%b", c, bus.d_rsp_data, bus.d_rsp_err, pdata, perr); end
            end
            pv_i  = gi;
            pv_d  = gd;
            perr  = 1'b0;
            pdata = 32'h0;
            if (gi || gd) begin
                a    = gi ? ia : da;
                ix   = a / 4;
                perr = addr_bad(a);
                if (!perr && (gi || !dwe)) pdata = exp_mem[ix[AW-1:0]];
                if (gd && dwe && !perr) exp_mem[ix[AW-1:0]] = dwd;
                if (gd) locked_m = dl;
                last_d_m = gd;
            end
            cyc();
        end
    endtask

    initial begin
        reset = 1'b0;
        idle();
        #2;
        test_reset();
        test_contention();
        test_write_then_read();
        test_lock();
        test_misaligned();
        test_out_of_range();
        test_reset_in_lock();
        test_random(400);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
